word_serializer_32: RTL

- Parallel-to-serial converter: accepts one WIDTH-bit word over a valid/ready handshake and emits it one bit per handshake beat.
- Inverse of the bit-to-word replication path. A word produced by replicating a single bit is flagged as uniform on its last beat.
- Sits between the ALU result bus and serial debug/transfer logic.

---
 rtl/word_serializer_32.sv | 96 +++++++++
 1 files changed

// File: rtl/word_serializer_32.sv
// Parallel-to-serial converter: takes one WIDTH-bit word over valid/ready and emits it one bit
// per accepted beat, flagging words made of a single replicated bit on the last beat.
module word_serializer_32 #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_bit_o,
  output logic             out_last_o,
  output logic             uniform_o,
  output logic             busy_o
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             uniform_q, uniform_d;

  logic             is_shift;
  logic             head_bit;
  logic             at_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      count_q   <= '0;
      uniform_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      count_q   <= count_d;
      uniform_q <= uniform_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    count_d   = count_q;
    uniform_d = uniform_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          shift_d   = in_data_i;
          count_d   = '0;
          uniform_d = (&in_data_i) | ~(|in_data_i);
          state_d   = StShift;
        end
      end
      StShift: begin
        if (out_ready_i) begin
          if (count_q == LastCnt) begin
            state_d = StIdle;
            count_d = '0;
            shift_d = '0;
          end else begin
            count_d = count_q + 1'b1;
            // Move the next bit toward the output end, zero-filling behind it.
            if (LSB_FIRST != 0) begin
              shift_d = {1'b0, shift_q[WIDTH-1:1]};
            end else begin
              shift_d = {shift_q[WIDTH-2:0], 1'b0};
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign is_shift = (state_q == StShift);
  assign head_bit = (LSB_FIRST != 0) ? shift_q[0] : shift_q[WIDTH-1];
  assign at_last  = is_shift & (count_q == LastCnt);

  always_comb begin
    in_ready_o  = ~is_shift;
    out_valid_o = is_shift;
    busy_o      = is_shift;
    out_bit_o   = is_shift & head_bit;
    out_last_o  = at_last;
    uniform_o   = at_last & uniform_q;
  end

endmodule
